// File: rtl/text_display_pkg.sv
// text_display_pkg: shared types and constants for the text display pipeline.
package text_display_pkg;
  localparam int CHAR_WIDTH = 8;
  localparam int DEFAULT_PIXEL_COLS = 128;
  localparam int DEFAULT_FETCH_LATENCY = 3;
  typedef enum logic [2:0] {IDLE, RESTART, SKIP, WAIT, EMIT, ADVANCE, DONE} streamer_state_t;
endpackage

// File: rtl/text_column_streamer_fetch_timer.sv
// pixel_fetch_timer: loadable down-counter; expired marks the last cycle of a LATENCY-cycle wait.
module pixel_fetch_timer
  import text_display_pkg::*;
#(
  parameter int LATENCY = DEFAULT_FETCH_LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);
  localparam int CW = $clog2(LATENCY + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? CW'(LATENCY - 1) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/text_column_streamer.sv
// text_column_streamer: walks the generator column stream via toggles and emits a window of bytes.
// Optional TEXT_COLUMN_STREAMER_BITREV_EN bit-reverses each captured byte.
module text_column_streamer
  import text_display_pkg::*;
#(
  parameter int PIXEL_COLS    = DEFAULT_PIXEL_COLS,
  parameter int BANDS         = 8,
  parameter int WIN_COLS      = 17,
  parameter int FETCH_LATENCY = DEFAULT_FETCH_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            x_offset,
  input  logic [2:0]            band_sel,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  toggle_restart,
  output logic                  toggle_next,
  input  logic [CHAR_WIDTH-1:0] cur_pixels,
  output logic [CHAR_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam int PW   = $clog2(PIXEL_COLS * BANDS);
  localparam int IW   = $clog2(WIN_COLS);
  localparam int XMAX = PIXEL_COLS - WIN_COLS;
  streamer_state_t state_q, state_d;
  logic [PW-1:0] skip_q, skip_d, p0;
  logic [IW-1:0] idx_q, idx_d;
  logic [CHAR_WIDTH-1:0] data_q, data_d, cap;
  logic tr_q, tr_d, tn_q, tn_d, load, expired, last;
  int x_eff, b_eff;
`ifdef TEXT_COLUMN_STREAMER_BITREV_EN
  assign cap = {<<{cur_pixels}};
`else
  assign cap = cur_pixels;
`endif
  assign last = idx_q == IW'(WIN_COLS - 1);
  always_comb begin
    x_eff = int'(x_offset) > XMAX ? XMAX : int'(x_offset);
    b_eff = int'(band_sel) > BANDS - 1 ? BANDS - 1 : int'(band_sel);
    p0 = PW'(b_eff * PIXEL_COLS + x_eff);
    state_d = state_q;
    skip_d = skip_q;
    idx_d = idx_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RESTART;
        skip_d = p0;
        idx_d = '0;
      end
      RESTART, SKIP: begin
        state_d = skip_q != '0 ? SKIP : WAIT;
        skip_d = skip_q != '0 ? skip_q - PW'(1) : skip_q;
      end
      WAIT: if (expired) begin
        state_d = EMIT;
        data_d = cap;
      end
      EMIT: if (out_ready) begin
        state_d = last ? DONE : ADVANCE;
        idx_d = idx_q + IW'(1);
      end
      ADVANCE: state_d = WAIT;
      default: state_d = IDLE;
    endcase
    // Each flip is registered on entry so it is visible during the state that owns it.
    tr_d = tr_q ^ (state_q == IDLE && start);
    tn_d = tn_q ^ (state_d == SKIP || state_d == ADVANCE);
    load = state_d == WAIT && state_q != WAIT;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      skip_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      tr_q <= 1'b0;
      tn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q <= skip_d;
      idx_q <= idx_d;
      data_q <= data_d;
      tr_q <= tr_d;
      tn_q <= tn_d;
    end
  pixel_fetch_timer #(.LATENCY(FETCH_LATENCY)) u_timer (
    .clk(clk), .reset(reset), .load(load), .expired(expired)
  );
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign out_valid = state_q == EMIT;
  assign out_last = state_q == EMIT && last;
  assign out_data = data_q;
  assign toggle_restart = tr_q;
  assign toggle_next = tn_q;
endmodule

// File: tb/tb_text_column_streamer.sv
// tb_text_column_streamer: directed bench with a toggle-driven generator model and byte scoreboard.
module tb_text_column_streamer;
  localparam int PC = 128, NB = 8, WC = 17, FL = 3;
  logic clk = 1'b0;
  logic reset, start, out_ready;
  logic [7:0] x_offset, cur_pixels, out_data;
  logic [2:0] band_sel;
  logic busy, frame_done, toggle_restart, toggle_next, out_valid, out_last;
  int vectors = 0, miscompares = 0;
  int cyc = 0, nflip = 0, ndone = 0, snap, dsnap;
  logic tn_prev = 1'b0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic pr = 1'b0, pn = 1'b0;
  logic [15:0] pos = '0, s2 = '0, s3 = '0;

  always #5 clk = ~clk;

  text_column_streamer dut (
    .clk(clk), .reset(reset), .start(start), .x_offset(x_offset), .band_sel(band_sel),
    .busy(busy), .frame_done(frame_done), .toggle_restart(toggle_restart),
    .toggle_next(toggle_next), .cur_pixels(cur_pixels), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  // Generator: restart has priority over next; data appears FL cycles after a visible flip.
  always @(posedge clk) begin
    pr <= toggle_restart;
    pn <= toggle_next;
    if (toggle_restart != pr) pos <= '0;
    else if (toggle_next != pn) pos <= pos + 16'd1;
    s2 <= pos;
    s3 <= s2;
  end
  assign cur_pixels = s3[7:0];

  function automatic logic [7:0] pix(int p);
    logic [7:0] b;
    b = p[7:0];
`ifdef TEXT_COLUMN_STREAMER_BITREV_EN
    return {<<{b}};
`else
    return b;
`endif
  endfunction

  function automatic int p0_of(int x, int b);
    int xe, be;
    xe = x > PC - WC ? PC - WC : x;
    be = b > NB - 1 ? NB - 1 : b;
    return be * PC + xe;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready && !reset) begin
      if (exp_q.size() == 0) chk("spurious_byte", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
        chk("out_last", {31'd0, out_last}, {31'd0, e[8]});
      end
    end
    if (out_valid) chk("no_flip_in_emit", {31'd0, toggle_next ^ tn_prev}, 0);
    if (toggle_next != tn_prev) nflip++;
    if (frame_done) ndone++;
    tn_prev = toggle_next;
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(int p0);
    for (int i = 0; i < WC; i++) exp_q.push_back({i == WC - 1, pix(p0 + i)});
  endtask

  task automatic do_start(int x, int b);
    x_offset = 8'(x);
    band_sel = 3'(b);
    snap = nflip;
    dsnap = ndone;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_valid();
    while (!out_valid && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    chk("valid_seen", {31'd0, out_valid}, 1);
  endtask

  task automatic wait_done();
    while (!frame_done && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    chk("frame_done_seen", {31'd0, frame_done}, 1);
    tick(1);
    chk("busy_falls", {31'd0, busy}, 0);
    tick(1);
    chk("frame_done_once", ndone - dsnap, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x_offset = '0; band_sel = '0; out_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_outputs", {23'd0, busy, frame_done, out_valid, out_last, toggle_restart, toggle_next, 3'd0}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    snap = nflip;
    tick(5);
    chk("idle_no_toggle", nflip - snap, 0);
    // Back-to-back frame: first byte at cycle 10, bytes spaced by 5 cycles.
    out_ready = 1'b1;
    push_frame(p0_of(5, 0));
    do_start(5, 0);
    wait_valid();
    chk("first_valid_cycle", cyc, 10);
    chk("skip_flips_x5", nflip - snap, 5);
    wait_done();
    chk("done_cycle", cyc, 91);
    // Band 2 offset 10, with an ignored start mid-frame.
    push_frame(p0_of(10, 2));
    do_start(10, 2);
    tick(20);
    cyc += 20;
    x_offset = 8'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc++;
    wait_valid();
    chk("skip_flips_266", nflip - snap, 266);
    chk("first_valid_b2", cyc, 266 + 5);
    wait_done();
    tick(3);
    chk("start_not_queued", {31'd0, busy}, 0);
    push_frame(p0_of(120, 0));
    do_start(120, 0);
    wait_valid();
    chk("skip_flips_clamp", nflip - snap, 111);
    wait_done();
    push_frame(p0_of(120, 7));
    do_start(120, 7);
    wait_valid();
    chk("skip_flips_b7", nflip - snap, 1007);
    wait_done();
    // Sink stalls for 10 cycles on byte 3.
    out_ready = 1'b0;
    push_frame(p0_of(30, 1));
    do_start(30, 1);
    for (int i = 0; i < WC; i++) begin
      wait_valid();
      if (i == 3) begin
        snap = nflip;
        for (int k = 0; k < 10; k++) begin
          chk("stall_valid", {31'd0, out_valid}, 1);
          chk("stall_data", {24'd0, out_data}, {24'd0, pix(158 + 3)});
          tick(1);
          cyc++;
        end
        chk("stall_no_flip", nflip - snap, 0);
      end
      out_ready = 1'b1;
      tick(1);
      cyc++;
      out_ready = 1'b0;
    end
    wait_done();
    // Reset during SKIP, then a fresh frame from offset 0.
    do_start(10, 2);
    tick(20);
    chk("busy_in_skip", {31'd0, busy}, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rst_mid_busy", {28'd0, busy, out_valid, toggle_restart, toggle_next}, 0);
    out_ready = 1'b1;
    push_frame(p0_of(0, 0));
    do_start(0, 0);
    wait_valid();
    chk("first_valid_p0_zero", cyc, 5);
    wait_done();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
